voice_allocator: RTL and testbench

//  Sequential voice scheduler between the MIDI parser and the synthesizer voice array.

---
 rtl/synth_pkg.sv | 12 +
 rtl/voice_cand_tracker.sv | 47 ++++
 rtl/voice_allocator.sv | 166 ++++++++++++++++
 tb/tb_voice_allocator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and sizing for the voice allocator slice.
package synth_pkg;

   localparam int VOICES_DEFAULT = 32;
   localparam int VOICE_IDX_W    = $clog2(VOICES_DEFAULT);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

   // Encoding order doubles as commit priority: lowest valid kind wins.
   typedef enum logic [1:0] {RETRIG, FREE, REL, OLDEST} cand_e;

endpackage

// File: rtl/voice_cand_tracker.sv
// Running best candidate over one scan: first hit, or first hit with the strictly largest age.
module voice_cand_tracker
   import synth_pkg::*;
#(
   parameter int IDX_W   = VOICE_IDX_W,
   parameter int AGE_W   = 8,
   parameter bit USE_AGE = 1'b0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic             hit_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [AGE_W-1:0] age_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             valid_q;
   logic [IDX_W-1:0] idx_q;
   logic [AGE_W-1:0] age_q;
   logic             take_d;

   // Strict compare keeps the lowest index on equal ages.
   always_comb begin
      take_d = en_i && hit_i && (!valid_q || (USE_AGE && (age_i > age_q)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         age_q   <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (take_d) begin
         valid_q <= 1'b1;
         idx_q   <= idx_i;
         age_q   <= age_i;
      end
   end

   assign valid_o = valid_q;
   assign idx_o   = idx_q;

endmodule

// File: rtl/voice_allocator.sv
// Voice scheduler: one voice scanned per cycle, then a single commit that picks
// retrigger > free > released > oldest and loads the chosen voice.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int VOICES  = VOICES_DEFAULT,
   parameter int KEY_W   = 7,
   parameter int VEL_W   = 7,
   parameter int STAMP_W = 8
)(
   input  logic                      CLOCK_50,
   input  logic                      reset,
   input  logic                      ev_valid,
   output logic                      ev_ready,
   input  logic                      ev_note_on,
   input  logic [KEY_W-1:0]          ev_key,
   input  logic [VEL_W-1:0]          ev_vel,
   input  logic                      all_off,
   input  logic [VOICES-1:0]         voice_free,
   output logic [VOICES-1:0]         keys_on,
   output logic                      vo_wr,
   output logic [$clog2(VOICES)-1:0] vo_idx,
   output logic [KEY_W-1:0]          vo_key,
   output logic [VEL_W-1:0]          vo_vel,
   output logic                      vo_steal
);

   localparam int IW = $clog2(VOICES);

   state_e             state_q;
   logic               ev_ready_q, ev_on_q, kill_q;
   logic [IW-1:0]      scan_idx_q;
   logic [KEY_W-1:0]   ev_key_q;
   logic [VEL_W-1:0]   ev_vel_q;
   logic [VOICES-1:0]  keys_on_q;
   logic [KEY_W-1:0]   key_q   [VOICES];
   logic [STAMP_W-1:0] stamp_q [VOICES];
   logic [STAMP_W-1:0] cur_stamp_q;
   logic               vo_wr_q, vo_steal_q;
   logic [IW-1:0]      vo_idx_q;
   logic [KEY_W-1:0]   vo_key_q;
   logic [VEL_W-1:0]   vo_vel_q;

   logic               accept_d, scan_en_d, scan_on_d;
   logic [STAMP_W-1:0] scan_age_d;
   logic [3:0]         hit_d;
   logic [3:0]         cand_valid;
   logic [IW-1:0]      cand_idx [4];
   cand_e              sel_kind_d;
   logic [IW-1:0]      sel_idx_d;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      accept_d   = (state_q == IDLE) && ev_valid && ev_ready_q;
      scan_en_d  = (state_q == SCAN) && ev_on_q;
      scan_on_d  = keys_on_q[scan_idx_q];
      scan_age_d = cur_stamp_q - stamp_q[scan_idx_q];
      hit_d         = '0;
      hit_d[RETRIG] = scan_on_d && (key_q[scan_idx_q] == ev_key_q);
      hit_d[FREE]   = voice_free[scan_idx_q] && !scan_on_d;
      hit_d[REL]    = !scan_on_d;
      hit_d[OLDEST] = 1'b1;
   end

   for (genvar k = 0; k < 4; k++) begin : g_cand
      voice_cand_tracker #(
         .IDX_W   (IW),
         .AGE_W   (STAMP_W),
         .USE_AGE (k >= 2)
      ) u_cand (
         .clk     (CLOCK_50),
         .reset   (reset),
         .clear_i (accept_d),
         .en_i    (scan_en_d),
         .hit_i   (hit_d[k]),
         .idx_i   (scan_idx_q),
         .age_i   (scan_age_d),
         .valid_o (cand_valid[k]),
         .idx_o   (cand_idx[k])
      );
   end

   always_comb begin
      sel_kind_d = OLDEST;
      sel_idx_d  = cand_idx[OLDEST];
      for (int k = 3; k >= 0; k--) begin
         if (cand_valid[k]) begin
            sel_kind_d = cand_e'(k[1:0]);
            sel_idx_d  = cand_idx[k];
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= IDLE;
         ev_ready_q  <= 1'b0;
         ev_on_q     <= 1'b0;
         kill_q      <= 1'b0;
         scan_idx_q  <= '0;
         ev_key_q    <= '0;
         ev_vel_q    <= '0;
         keys_on_q   <= '0;
         cur_stamp_q <= '0;
         vo_wr_q     <= 1'b0;
         vo_idx_q    <= '0;
         vo_key_q    <= '0;
         vo_vel_q    <= '0;
         vo_steal_q  <= 1'b0;
         // NOTE: key/stamp are flop arrays, not RAM, so clearing them on reset is legal and cheap to reason about.
         for (int v = 0; v < VOICES; v++) begin
            key_q[v]   <= '0;
            stamp_q[v] <= '0;
         end
      end else begin
         vo_wr_q <= 1'b0;
         kill_q  <= kill_q | all_off;
         case (state_q)
            IDLE: begin
               ev_ready_q <= 1'b1;
               if (accept_d) begin
                  state_q    <= SCAN;
                  ev_ready_q <= 1'b0;
                  scan_idx_q <= '0;
                  ev_on_q    <= ev_note_on && (ev_vel != '0);
                  ev_key_q   <= ev_key;
                  ev_vel_q   <= ev_vel;
                  kill_q     <= all_off;
               end
            end
            SCAN: begin
               if (!ev_on_q && hit_d[RETRIG]) keys_on_q[scan_idx_q] <= 1'b0;
               scan_idx_q <= scan_idx_q + 1'b1;
               if (scan_idx_q == IW'(VOICES - 1)) state_q <= COMMIT;
            end
            COMMIT: begin
               state_q    <= IDLE;
               ev_ready_q <= 1'b1;
               if (ev_on_q) begin
                  if (!kill_q) keys_on_q[sel_idx_d] <= 1'b1;
                  key_q[sel_idx_d]   <= ev_key_q;
                  stamp_q[sel_idx_d] <= cur_stamp_q;
                  cur_stamp_q        <= cur_stamp_q + 1'b1;
                  vo_wr_q            <= 1'b1;
                  vo_idx_q           <= sel_idx_d;
                  vo_key_q           <= ev_key_q;
                  vo_vel_q           <= ev_vel_q;
                  vo_steal_q         <= (sel_kind_d == REL) || (sel_kind_d == OLDEST);
               end
            end
            default: state_q <= IDLE;
         endcase
         // NOTE: non-blocking last-assignment-wins lets all_off override any per-voice set/clear above.
         if (all_off) keys_on_q <= '0;
      end
   end

   assign ev_ready = ev_ready_q;
   assign keys_on  = keys_on_q;
   assign vo_wr    = vo_wr_q;
   assign vo_idx   = vo_idx_q;
   assign vo_key   = vo_key_q;
   assign vo_vel   = vo_vel_q;
   assign vo_steal = vo_steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation priority, release, all_off, reset, stamp wrap.
module tb_voice_allocator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic        ev_note_on = 1'b0;
   logic [6:0]  ev_key = '0;
   logic [6:0]  ev_vel = '0;
   logic        all_off = 1'b0;
   logic [31:0] voice_free = '0;
   logic [31:0] keys_on;
   logic        vo_wr;
   logic [4:0]  vo_idx;
   logic [6:0]  vo_key;
   logic [6:0]  vo_vel;
   logic        vo_steal;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   voice_allocator dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_note_on (ev_note_on),
      .ev_key     (ev_key),
      .ev_vel     (ev_vel),
      .all_off    (all_off),
      .voice_free (voice_free),
      .keys_on    (keys_on),
      .vo_wr      (vo_wr),
      .vo_idx     (vo_idx),
      .vo_key     (vo_key),
      .vo_vel     (vo_vel),
      .vo_steal   (vo_steal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      ev_valid = 1'b0;
      all_off  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // One event end to end; ao_off > 0 pulses all_off in cycle T+ao_off.
   task automatic run_ev(input bit on, input logic [6:0] key, input logic [6:0] vel, input int ao_off,
                         output bit wr, output logic [4:0] idx, output logic [6:0] okey,
                         output logic [6:0] ovel, output logic steal, output int lat,
                         output logic [31:0] ko1, output logic [31:0] ko2,
                         output logic [31:0] ko_ao, output logic [31:0] ko_end);
      int t;
      int n;
      wr = 1'b0; idx = '0; okey = '0; ovel = '0; steal = 1'b0; lat = -1;
      ko1 = '0; ko2 = '0; ko_ao = '0; ko_end = '0;
      @(negedge clk);
      ev_valid = 1'b1; ev_note_on = on; ev_key = key; ev_vel = vel;
      n = 0;
      while (!ev_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ev_ready) begin
         check("accept_timeout", 64'(ev_ready), 64'd1);
         ev_valid = 1'b0;
         return;
      end
      t = cyc;
      @(negedge clk);
      ev_valid = 1'b0; ev_note_on = ~on; ev_key = ~key; ev_vel = ~vel;
      for (int i = 0; i < 60; i++) begin
         if (cyc == t + 1) ko1 = keys_on;
         if (cyc == t + 2) ko2 = keys_on;
         if (ao_off > 0 && cyc == t + ao_off + 1) ko_ao = keys_on;
         if (vo_wr) begin
            wr = 1'b1; idx = vo_idx; okey = vo_key; ovel = vo_vel; steal = vo_steal;
         end
         if (ev_ready) break;
         if (ao_off > 0 && cyc == t + ao_off) all_off = 1'b1;
         @(negedge clk);
         all_off = 1'b0;
      end
      lat    = cyc - t;
      ko_end = keys_on;
   endtask

   bit          wr;
   logic [4:0]  idx;
   logic [6:0]  okey, ovel;
   logic        steal;
   int          lat;
   logic [31:0] ko1, ko2, ko_ao, ko_end;

   initial begin
      int seen, prev, wr_seen;

      // Reset values
      @(negedge clk);
      check("rst_ready", 64'(ev_ready), 64'd0);
      check("rst_outs", {keys_on, vo_wr, vo_idx, vo_key, vo_vel, vo_steal}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(ev_ready), 64'd1);

      // 1: first note-on lands on voice 0 at T+34
      voice_free = '1;
      run_ev(1'b1, 7'd60, 7'd100, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t1_wr", 64'(wr), 64'd1);
      check("t1_vo", {idx, okey, ovel, steal}, {5'd0, 7'd60, 7'd100, 1'b0});
      check("t1_lat", 64'(lat), 64'd34);
      check("t1_keys", 64'(ko_end), 64'h1);

      // 2: retrigger same key
      run_ev(1'b1, 7'd60, 7'd90, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t2_vo", {wr, idx, okey, ovel, steal}, {1'b1, 5'd0, 7'd60, 7'd90, 1'b0});
      check("t2_keys", 64'(ko_end), 64'h1);

      // 3: note-off, unmatched note-off, vel-0 note-on
      run_ev(1'b0, 7'd60, 7'd0, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t3_off_wr", 64'(wr), 64'd0);
      check("t3_off_k1", 64'(ko1[0]), 64'd1);
      check("t3_off_k2", 64'(ko2[0]), 64'd0);
      check("t3_off_lat", 64'(lat), 64'd34);
      run_ev(1'b1, 7'd60, 7'd100, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t3_on_again", {wr, idx, steal, ko_end}, {1'b1, 5'd0, 1'b0, 32'h1});
      run_ev(1'b0, 7'd61, 7'd0, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t3_unmatched", {wr, ko_end}, {1'b0, 32'h1});
      run_ev(1'b1, 7'd60, 7'd0, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t3_vel0_off", {wr, ko_end}, {1'b0, 32'h0});

      // 4: fill all voices, release key 45, steal released voice 5
      do_reset();
      voice_free = '1;
      for (int i = 0; i < 32; i++) begin
         run_ev(1'b1, 7'(40 + i), 7'd64, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
         check($sformatf("t4_fill_%0d", i), {wr, idx, steal}, {1'b1, 5'(i), 1'b0});
      end
      check("t4_full", 64'(ko_end), 64'hFFFF_FFFF);
      run_ev(1'b0, 7'd45, 7'd0, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t4_rel45", {wr, ko_end}, {1'b0, 32'hFFFF_FFDF});
      voice_free = '0;
      run_ev(1'b1, 7'd80, 7'd77, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t4_steal_rel", {wr, idx, okey, steal, ko_end}, {1'b1, 5'd5, 7'd80, 1'b1, 32'hFFFF_FFFF});

      do_reset();
      voice_free = '1;
      for (int i = 0; i < 32; i++)
         run_ev(1'b1, 7'(40 + i), 7'd64, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      voice_free = '0;
      run_ev(1'b1, 7'd80, 7'd77, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t4_steal_oldest", {wr, idx, steal}, {1'b1, 5'd0, 1'b1});

      // 5: all_off during scan, then reset during scan
      do_reset();
      voice_free = '1;
      run_ev(1'b1, 7'd60, 7'd100, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      run_ev(1'b1, 7'd61, 7'd50, 5, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t5_ao_next", 64'(ko_ao), 64'h0);
      check("t5_ao_commit", {wr, idx, okey, steal, ko_end}, {1'b1, 5'd1, 7'd61, 1'b0, 32'h0});
      run_ev(1'b1, 7'd62, 7'd50, 0, wr, idx, okey, ovel, steal, lat, ko1, ko2, ko_ao, ko_end);
      check("t5_after_ao", {wr, idx, ko_end}, {1'b1, 5'd0, 32'h1});

      @(negedge clk);
      ev_valid = 1'b1; ev_note_on = 1'b1; ev_key = 7'd70; ev_vel = 7'd33;
      @(negedge clk);
      ev_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_mid", {ev_ready, keys_on}, {1'b0, 32'h0});
      reset = 1'b0;
      @(negedge clk);
      check("t5_rst_ready", 64'(ev_ready), 64'd1);
      wr_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (vo_wr) wr_seen++;
         @(negedge clk);
      end
      check("t5_rst_no_wr", 64'(wr_seen), 64'd0);

      // 6: back-to-back with ev_valid held high
      do_reset();
      ev_valid = 1'b1; ev_note_on = 1'b0; ev_key = 7'd127; ev_vel = 7'd0;
      seen = 0;
      prev = -1;
      for (int i = 0; i < 170; i++) begin
         if (ev_ready) begin
            seen++;
            if (prev >= 0) check($sformatf("t6_gap_%0d", seen), 64'(cyc - prev), 64'd34);
            prev = cyc;
         end
         @(negedge clk);
      end
      ev_valid = 1'b0;
      check("t6_ready_count", 64'(seen), 64'd5);

      // 6: 300 allocations with no free voices; stamps wrap, oldest is always stolen
      do_reset();
      voice_free = '0;
      for (int k = 0; k < 300; k++) begin
         run_ev(1'b1, 7'(k % 128), 7'(k % 100 + 1), 0, wr, idx, okey, ovel, steal, lat,
                ko1, ko2, ko_ao, ko_end);
         check($sformatf("t6_wrap_%0d", k), {wr, idx, steal}, {1'b1, 5'(k % 32), 1'b1});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
